uart_byte_receiver: RTL and testbench
=====================================

// Module: uart_byte_receiver
// PURPOSE
//   Serial front end feeding the Riscv151 core's FPGA_SERIAL_RX path.
//   Synchronises the asynchronous RX pin and deserialises 8N1 frames (LSB first).
//   Presents each received byte on a ready/valid interface to the CPU's memory-mapped UART logic.
//   Reports framing errors and overruns as single-cycle pulses.
// PARAMETERS
//   CLOCK_FREQ   50_000_000  core clock frequency, Hz
//   BAUD_RATE    115_200     line rate, bit/s
//   (derived, localparam)
//     SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division)
//     SAMPLE_TIME = SYMBOL_EDGE_TIME/2
//     CNT_W = $clog2(SYMBOL_EDGE_TIME)
// PORTS
//   clk             in   1  core clock; sole clock domain
//   rst             in   1  synchronous, active-high reset
//   serial_in       in   1  asynchronous RX pin; idle high
//   data_out        out  8  received byte; stable while data_out_valid=1
//   data_out_valid  out  1  byte available
//   data_out_ready  in   1  consumer accepts the byte on a posedge where valid&ready
//   framing_error   out  1  one-cycle pulse: stop bit sampled as 0
//   overrun         out  1  one-cycle pulse: new byte dropped because the held byte was unconsumed
// BEHAVIOUR
//   Reset
//     clk is the only clock; rst is synchronous and active-high.
//     While rst=1: data_out=0, data_out_valid=0, framing_error=0, overrun=0.
//     Also on rst: state=IDLE, counters=0, both synchroniser flops=1.
//     rst mid-frame aborts the frame: no valid, no error pulse.
//   Synchroniser
//     serial_in passes through a 2-flop synchroniser; all logic uses the synced bit (rx).
//   FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
//     IDLE: rx=0 -> START, counter cleared.
//     START: count SAMPLE_TIME cycles, then sample rx (mid start bit).
//       rx=1 -> IDLE (glitch rejected).
//       rx=0 -> DATA, counter cleared, bit index=0.
//     DATA: every SYMBOL_EDGE_TIME cycles sample rx into shift[bit index]. After bit 7 -> STOP.
//     STOP: after SYMBOL_EDGE_TIME cycles sample rx.
//       rx=1: byte complete -> IDLE.
//       rx=0: framing_error=1 for exactly the next cycle; byte discarded -> WAIT_HIGH.
//     WAIT_HIGH: stay until rx=1, then -> IDLE. A held-low line never retriggers a start.
//   Output register / handshake
//     On byte complete with data_out_valid=0: data_out<=shift, valid<=1 next cycle.
//     valid&ready at a posedge: valid<=0 next cycle, unless a byte completes that same cycle.
//       In that case data_out<=new byte and valid stays 1; no overrun.
//     Byte complete while valid=1 and ready=0: new byte dropped; data_out unchanged; overrun=1 next cycle only.
//     data_out never changes while valid=1 except through the accept+complete case above.
//   Latency
//     valid rises 1 cycle after the stop-bit sample.
//     That is 2 + 1 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME (+/-1) cycles after the pin's falling edge.
//   Width / wrap
//     Counter counts 0..SYMBOL_EDGE_TIME-1 and reloads 0; it never wraps naturally.
//     Bit index is 3 bits, 0..7.
//     Frames are LSB first; an idle-high line with the byte held leaves outputs untouched.
// TESTING (bench params CLOCK_FREQ=1000, BAUD_RATE=100: 10 cycles/bit, SAMPLE_TIME=5)
//   1. Drive frame 0xA5, ready=0.
//      -> valid=1, data_out=0xA5, held indefinitely.
//      -> Pulse ready for 1 cycle: valid=0 next cycle.
//   2. Low glitch of 3 cycles on idle line.
//      -> No valid, no error pulses.
//      -> Following frame 0x3C is received as 0x3C.
//   3. Frame 0x55 with stop bit 0, line held low 30 more cycles, then high.
//      -> Exactly one framing_error pulse, no valid.
//      -> Next frame 0x81 is received correctly.
//   4. Back-to-back frames 0x11, 0x22 with ready=0.
//      -> data_out stays 0x11; one overrun pulse at the second stop sample.
//      -> ready=1 then clears valid.
//   5. ready tied 1, back-to-back frames 0x00, 0xFF.
//      -> Two valid&ready handshakes, data 0x00 then 0xFF; overrun never asserted.
//   6. rst asserted for 2 cycles during data bit 4 of a frame.
//      -> All outputs 0, no valid from the aborted frame.
//      -> Next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with 2-flop RX synchroniser, ready/valid byte
// output and single-cycle framing-error / overrun pulses.
module uart_byte_receiver #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SymLast    = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SampleLast = CNT_W'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q;
  logic             rx_q;

  // Two-flop synchroniser for the asynchronous RX pin; resets to the idle-high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= serial_in;
      rx_q      <= rx_meta_q;
    end
  end

  // Frame FSM, deserialiser and registered output handshake / status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // Consumer accept; a byte completing this same cycle overrides below.
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_q) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          if (cnt_q == SampleLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A high level at mid start bit is a glitch, not a frame.
            state_q   <= rx_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StData: begin
          if (cnt_q == SymLast) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_q;
            bit_idx_q          <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (cnt_q == SymLast) begin
            cnt_q <= '0;
            if (rx_q) begin
              state_q <= StIdle;
              // Slot is free if empty or being emptied this very cycle.
              if (!data_out_valid || data_out_ready) begin
                data_out       <= shift_q;
                data_out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state_q       <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StWaitHigh: begin
          // A line stuck low after a bad stop bit must not be taken as a new start bit.
          cnt_q <= '0;
          if (rx_q) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: 10 clocks per bit, directed scenarios plus a
// randomized frame phase with random ready and random framing errors.
module tb_uart_byte_receiver;

  localparam int unsigned ClockFreq = 1000;
  localparam int unsigned BaudRate  = 100;
  localparam int          BitCycles = ClockFreq / BaudRate;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_byte_receiver #(
    .CLOCK_FREQ(ClockFreq),
    .BAUD_RATE (BaudRate)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vr_cnt = 0;
  int hs_cnt = 0;
  int fe_exp = 0;
  int ov_exp = 0;

  // 0: ready low, 1: ready high, 2: random each cycle
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sole driver of data_out_ready, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       data_out_ready = 1'b0;
      1:       data_out_ready = 1'b1;
      default: data_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sampled on falling edges, values seen here are what the next rising edge uses.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst   = 1'b1;
  logic       prev_fe    = 1'b0;
  logic       prev_ov    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL handshake: got unexpected byte 0x%0h, required none", data_out);
        end else begin
          check("handshake_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (!prev_rst && prev_valid && !prev_ready) begin
        check("held_valid", 32'(data_out_valid), 32'd1);
        check("held_data", 32'(data_out), 32'(prev_data));
      end
      if (data_out_valid && !prev_valid) vr_cnt++;
      if (framing_error) begin
        if (prev_fe) check("fe_pulse_width", 32'd2, 32'd1);
        else fe_cnt++;
      end
      if (overrun) begin
        if (prev_ov) check("ov_pulse_width", 32'd2, 32'd1);
        else ov_cnt++;
      end
    end
    prev_valid = data_out_valid;
    prev_ready = data_out_ready;
    prev_rst   = rst;
    prev_fe    = framing_error;
    prev_ov    = overrun;
    prev_data  = data_out;
  end

  task automatic line(input logic v, input int cycles);
    serial_in = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
    line(1'b0, BitCycles);
    for (int i = 0; i < 8; i++) line(b[i], BitCycles);
    line(stop_bit, BitCycles);
    if (!stop_bit && extra_low > 0) line(1'b0, extra_low);
    serial_in = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    while (!data_out_valid && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (!data_out_valid) check(name, 32'(data_out_valid), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_data"}, 32'(data_out), 32'd0);
    check({name, "_valid"}, 32'(data_out_valid), 32'd0);
    check({name, "_fe"}, 32'(framing_error), 32'd0);
    check({name, "_ov"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, ov0, vr0, hs0;
    logic [7:0] b;
    logic [7:0] rb;

    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    line(1'b1, 20);

    // 1: byte held with ready low, then a one-cycle ready pulse
    ready_mode = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    wait_valid("t1_valid_timeout", 20);
    line(1'b1, 50);
    check("t1_valid_held", 32'(data_out_valid), 32'd1);
    check("t1_data", 32'(data_out), 32'hA5);
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    ready_mode = 0;
    @(negedge clk);
    check("t1_valid_cleared", 32'(data_out_valid), 32'd0);
    line(1'b1, 10);

    // 2: short low glitch is ignored, then a clean frame
    fe0 = fe_cnt; vr0 = vr_cnt;
    line(1'b0, 3);
    line(1'b1, 20);
    check("t2_glitch_no_valid", 32'(vr_cnt - vr0), 32'd0);
    check("t2_glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    ready_mode = 1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    line(1'b1, 10);

    // 3: bad stop bit with line held low, then recovery
    fe0 = fe_cnt; vr0 = vr_cnt;
    send_frame(8'h55, 1'b0, 30);
    fe_exp++;
    line(1'b1, 10);
    check("t3_one_fe", 32'(fe_cnt - fe0), 32'd1);
    check("t3_no_valid", 32'(vr_cnt - vr0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    line(1'b1, 10);

    // 4: back-to-back frames into a full slot
    ready_mode = 0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    ov_exp++;
    line(1'b1, 5);
    check("t4_one_overrun", 32'(ov_cnt - ov0), 32'd1);
    check("t4_data_kept", 32'(data_out), 32'h11);
    ready_mode = 1;
    line(1'b1, 5);
    check("t4_valid_cleared", 32'(data_out_valid), 32'd0);

    // 5: ready tied high, back-to-back frames
    ov0 = ov_cnt; hs0 = hs_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 0);
    line(1'b1, 10);
    check("t5_two_handshakes", 32'(hs_cnt - hs0), 32'd2);
    check("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // 6: reset during data bit 4; remaining bits are 1 so the tail cannot look like a start
    vr0 = vr_cnt;
    b = 8'hF5;
    line(1'b0, BitCycles);
    for (int i = 0; i < 4; i++) line(b[i], BitCycles);
    line(b[4], 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("t6_in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    line(b[4], 5);
    for (int i = 5; i < 8; i++) line(b[i], BitCycles);
    line(1'b1, BitCycles + 20);
    check("t6_no_valid", 32'(vr_cnt - vr0), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0);
    line(1'b1, 10);

    // Random phase: random bytes, gaps, ready and occasional bad stop bits
    ready_mode = 2;
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        send_frame(rb, 1'b0, int'($urandom_range(0, 20)));
        fe_exp++;
      end else begin
        exp_q.push_back(rb);
        send_frame(rb, 1'b1, 0);
      end
      line(1'b1, int'($urandom_range(2, 15)));
    end

    // Drain
    ready_mode = 1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    line(1'b1, 5);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("total_framing_errors", 32'(fe_cnt), 32'(fe_exp));
    check("total_overruns", 32'(ov_cnt), 32'(ov_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
